char_seq_counter: RTL and testbench

//  Parametrised successor to the single-pattern character FSM: scans a byte-serial

---
 rtl/char_fsm_pkg.sv | 26 ++
 rtl/char_seq_counter_window.sv | 38 +++
 rtl/char_seq_counter.sv | 131 +++++++++++++
 tb/tb_char_seq_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/char_fsm_pkg.sv
// Shared state encoding, ASCII constants and case-folding helper for the
// character sequence counter.
package char_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_QUERY = 8'h3F;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] ASCII_CASE  = 8'h20;

  // Width-agnostic up to 32 bits; callers size-cast to their character width.
  function automatic logic [31:0] fold_upper(input logic [31:0] c, input logic nocase);
    logic [31:0] r;
    r = c;
    if (nocase && (c >= 32'(ASCII_LC_A)) && (c <= 32'(ASCII_LC_Z)))
      r = c - 32'(ASCII_CASE);
    return r;
  endfunction

endpackage

// File: rtl/char_seq_counter_window.sv
// Sliding character window: newest character enters at the LSB end, with a
// saturating fill count of valid characters held.
module char_window
  import char_fsm_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int PAT_LEN = 4
) (
  input  logic                           clk,
  input  logic                           shift,
  input  logic                           clear,
  input  logic [CHAR_W-1:0]              din,
  output logic [PAT_LEN*CHAR_W-1:0]      window,
  output logic [$clog2(PAT_LEN+1)-1:0]   fill,
  output logic                           full
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN*CHAR_W-1:0] r_win;
  logic [FILL_W-1:0]         r_fill;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_win <= (PAT_LEN*CHAR_W)'({r_win, din});
      if (r_fill != FILL_W'(PAT_LEN))
        r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign window = r_win;
  assign fill   = r_fill;
  assign full   = (r_fill == FILL_W'(PAT_LEN));

endmodule

// File: rtl/char_seq_counter.sv
// Framed pattern counter: counts PATTERN occurrences between START_CHAR and
// END_CHAR with optional overlap, case folding and saturating count.
module char_seq_counter
  import char_fsm_pkg::*;
#(
  parameter int                           CHAR_W     = 8,
  parameter int                           PAT_LEN    = 4,
  parameter logic [PAT_LEN*CHAR_W-1:0]    PATTERN    = "BUAA",
  parameter int                           CNT_W      = 8,
  parameter int                           OVERLAP    = 1,
  parameter logic [CHAR_W-1:0]            START_CHAR = "#",
  parameter logic [CHAR_W-1:0]            END_CHAR   = "?"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] in,
  input  logic              in_valid,
  input  logic              nocase,
  output logic [CNT_W-1:0]  cnt,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  for (genvar g = 0; g < PAT_LEN; g++) begin : g_pat_check
    if ((PATTERN[g*CHAR_W +: CHAR_W] == START_CHAR) ||
        (PATTERN[g*CHAR_W +: CHAR_W] == END_CHAR)) begin : g_bad
      $error("char_seq_counter: PATTERN contains a frame delimiter");
    end
  end

  state_t                    r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_match, r_ovf;
  logic                      w_start, w_end, w_shift, w_hit, w_eq, w_full_next;
  logic                      w_win_clear, w_full;
  logic [PAT_LEN*CHAR_W-1:0] w_window, w_next_win;
  logic [FILL_W-1:0]         w_fill;

  char_window #(
    .CHAR_W (CHAR_W),
    .PAT_LEN(PAT_LEN)
  ) u_window (
    .clk   (clk),
    .shift (w_shift),
    .clear (w_win_clear),
    .din   (in),
    .window(w_window),
    .fill  (w_fill),
    .full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    w_shift      = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        IDLE, DONE: begin
          if (in == START_CHAR) begin
            w_state_next = RUN;
            w_start      = 1'b1;
          end
        end
        RUN: begin
          if (in == START_CHAR) begin
            w_start = 1'b1;
          end else if (in == END_CHAR) begin
            w_state_next = DONE;
            w_end        = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Compare against the window as it will be after this character shifts in,
  // so the match registers on the same edge the final character is sampled.
  assign w_next_win  = (PAT_LEN*CHAR_W)'({w_window, in});
  assign w_full_next = w_full || (w_fill == FILL_W'(PAT_LEN - 1));

  always_comb begin
    w_eq = 1'b1;
    for (int unsigned i = 0; i < PAT_LEN; i++) begin
      if (CHAR_W'(fold_upper(32'(w_next_win[i*CHAR_W +: CHAR_W]), nocase)) !=
          CHAR_W'(fold_upper(32'(PATTERN[i*CHAR_W +: CHAR_W]), nocase)))
        w_eq = 1'b0;
    end
  end

  always_comb begin
    w_hit       = w_shift && w_full_next && w_eq;
    w_win_clear = reset || w_start || w_end || (w_hit && (OVERLAP == 0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_start) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_hit) begin
        if (r_cnt == '1) r_ovf <= 1'b1;
        else             r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt      = r_cnt;
  assign match    = r_match;
  assign overflow = r_ovf;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_char_seq_counter.sv
// Bench for char_seq_counter: four parameterisations share one stimulus stream
// and are checked every cycle against a queue-based frame/match model.
module tb_char_seq_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_ch;
  logic       in_valid;
  logic       nocase;

  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic [3:0] match_v, busy_v, done_v, ovf_v;
  logic [7:0] cnt_a [4];

  always #5 clk = ~clk;

  char_seq_counter u0 (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid), .nocase(nocase),
    .cnt(cnt0), .match(match_v[0]), .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]));

  char_seq_counter #(.PAT_LEN(2), .PATTERN("AA"), .OVERLAP(1)) u1 (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid), .nocase(nocase),
    .cnt(cnt1), .match(match_v[1]), .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]));

  char_seq_counter #(.PAT_LEN(2), .PATTERN("AA"), .OVERLAP(0)) u2 (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid), .nocase(nocase),
    .cnt(cnt2), .match(match_v[2]), .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]));

  char_seq_counter #(.CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid), .nocase(nocase),
    .cnt(cnt3), .match(match_v[3]), .busy(busy_v[3]), .done(done_v[3]), .overflow(ovf_v[3]));

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = cnt2;
  assign cnt_a[3] = {6'b0, cnt3};

  string pat     [4] = '{"BUAA", "AA", "AA", "BUAA"};
  bit    overlap [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int    cnt_max [4] = '{255, 255, 255, 3};

  bit          m_open  [4];
  bit          m_closed[4];
  int          m_cnt   [4];
  bit          m_ovf   [4];
  bit          m_match [4];
  int          m_pulses[4];
  byte unsigned hist   [4][$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic byte unsigned fold(byte unsigned c, bit nc);
    if (nc && c >= "a" && c <= "z") return c - 8'd32;
    return c;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_open[k] = 0; m_closed[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_match[k] = 0;
      hist[k].delete();
    end
  endfunction

  function automatic void model_step(byte unsigned ch, bit v, bit nc);
    for (int k = 0; k < 4; k++) begin
      bit same;
      m_match[k] = 0;
      if (!v) continue;
      if (ch == "#") begin
        m_open[k] = 1; m_closed[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        hist[k].delete();
      end else if (!m_open[k]) begin
        // outside a frame everything but '#' is ignored
      end else if (ch == "?") begin
        m_open[k] = 0; m_closed[k] = 1;
        hist[k].delete();
      end else begin
        hist[k].push_back(ch);
        if (hist[k].size() > pat[k].len()) void'(hist[k].pop_front());
        if (hist[k].size() == pat[k].len()) begin
          same = 1;
          for (int i = 0; i < pat[k].len(); i++)
            if (fold(hist[k][i], nc) != fold(pat[k][i], nc)) same = 0;
          if (same) begin
            m_match[k] = 1;
            m_pulses[k]++;
            if (m_cnt[k] == cnt_max[k]) m_ovf[k] = 1;
            else m_cnt[k]++;
            if (!overlap[k]) hist[k].delete();
          end
        end
      end
    end
  endfunction

  task automatic chk(string tag, int k, logic [7:0] got, logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[u%0d] t=%0t: got %0h expected %0h", tag, k, $time, got, exp);
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk("cnt",      k, cnt_a[k],         8'(m_cnt[k]));
      chk("match",    k, {7'b0, match_v[k]}, {7'b0, m_match[k]});
      chk("busy",     k, {7'b0, busy_v[k]},  {7'b0, m_open[k]});
      chk("done",     k, {7'b0, done_v[k]},  {7'b0, m_closed[k]});
      chk("overflow", k, {7'b0, ovf_v[k]},   {7'b0, m_ovf[k]});
    end
  endtask

  task automatic tick(byte unsigned ch, bit v, bit nc);
    in_ch = ch; in_valid = v; nocase = nc;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step(ch, v, nc);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send(string s, int gap, bit nc);
    for (int i = 0; i < s.len(); i++) begin
      tick(s[i], 1'b1, nc);
      for (int g = 0; g < gap; g++) tick(8'h00, 1'b0, nc);
    end
  endtask

  initial begin
    int p0;
    byte unsigned alpha [10] = '{"B", "U", "A", "A", "b", "a", "X", "#", "?", "A"};
    for (int k = 0; k < 4; k++) m_pulses[k] = 0;
    reset = 1'b1; in_ch = 8'h00; in_valid = 1'b0; nocase = 1'b0;
    model_reset();
    tick(8'h00, 1'b0, 1'b0);
    do_reset();
    chk("reset_cnt", 0, cnt0, 8'd0);
    chk("reset_busy", 0, {7'b0, busy_v[0]}, 8'd0);

    p0 = m_pulses[0];
    send("#BUAAX BUA?", 0, 1'b0);
    chk("t1_cnt", 0, cnt0, 8'd1);
    chk("t1_done", 0, {7'b0, done_v[0]}, 8'd1);
    chk("t1_busy", 0, {7'b0, busy_v[0]}, 8'd0);
    chk("t1_pulses", 0, 8'(m_pulses[0] - p0), 8'd1);

    send("#AAAA?", 0, 1'b0);
    chk("t2_ovl", 1, cnt1, 8'd3);
    chk("t2_novl", 2, cnt2, 8'd2);

    send("#buaa?", 0, 1'b1);
    chk("t3_nocase", 0, cnt0, 8'd1);
    send("#buaa?", 0, 1'b0);
    chk("t3_case", 0, cnt0, 8'd0);
    do_reset();
    send("BUAA#?", 0, 1'b0);
    chk("t3_prefix", 0, cnt0, 8'd0);

    p0 = m_pulses[3];
    send("#BUAABUAABUAABUAABUAA?", 0, 1'b0);
    chk("t4_cnt", 3, {6'b0, cnt3}, 8'd3);
    chk("t4_ovf", 3, {7'b0, ovf_v[3]}, 8'd1);
    chk("t4_pulses", 3, 8'(m_pulses[3] - p0), 8'd5);
    send("#", 0, 1'b0);
    chk("t4_clr_cnt", 3, {6'b0, cnt3}, 8'd0);
    chk("t4_clr_ovf", 3, {7'b0, ovf_v[3]}, 8'd0);

    send("#BUAA?", 3, 1'b0);
    chk("t5_gaps", 0, cnt0, 8'd1);
    send("#BU", 0, 1'b0);
    do_reset();
    chk("t5_rst_busy", 0, {7'b0, busy_v[0]}, 8'd0);
    send("AA?", 0, 1'b0);
    chk("t5_after_rst", 0, cnt0, 8'd0);
    chk("t5_done", 0, {7'b0, done_v[0]}, 8'd0);

    send("#BUA#BUAA?", 0, 1'b0);
    chk("t6_restart", 0, cnt0, 8'd1);
    send("BUAA?", 0, 1'b0);
    chk("t6_held_cnt", 0, cnt0, 8'd1);
    chk("t6_held_done", 0, {7'b0, done_v[0]}, 8'd1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick(alpha[$urandom_range(0, 9)], ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
